// File: rtl/jump_button_poller_if.sv
// Avalon-MM read-only bus between the button poller (master) and the GPIO slave.
interface jump_button_poller_if;
   logic [1:0]  avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_waitrequest,
      input  avm_readdata,
      input  avm_readdatavalid
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_waitrequest,
      output avm_readdata,
      output avm_readdatavalid
   );
endinterface

// File: rtl/jump_button_poller.sv
// Periodically reads a button over Avalon-MM, debounces bit 0 and emits edge strobes.
// A read that never returns data is abandoned after TIMEOUT cycles and flagged.
module jump_button_poller #(
   parameter int unsigned POLL_DIV     = 50000,
   parameter int unsigned DEBOUNCE_CNT = 4,
   parameter int unsigned TIMEOUT      = 255,
   parameter logic [1:0]  RD_ADDR      = 2'd0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 clear_err,
   jump_button_poller_if.master avm,
   output logic                 jump_level,
   output logic                 jump_pulse,
   output logic                 release_pulse,
   output logic                 timeout_err
);

   localparam logic [23:0] PollLast = 24'(POLL_DIV - 1);
   localparam logic [15:0] TmoLast  = 16'(TIMEOUT - 1);
   localparam logic [3:0]  DbMax    = 4'(DEBOUNCE_CNT);

   typedef enum logic [1:0] {StIdle, StReq, StWaitData} state_e;

   state_e      state;
   logic [23:0] poll_cnt;
   logic [15:0] tmo_cnt;
   logic [3:0]  match_cnt;
   logic        candidate;
   logic        read_req;

   logic        sample;
   logic        cand_nxt;
   logic [3:0]  match_nxt;
   logic        unused_readdata;

   assign avm.avm_address = RD_ADDR;
   assign avm.avm_read    = read_req;
   assign sample          = avm.avm_readdata[0];
   assign unused_readdata = ^avm.avm_readdata[31:1];

   always_comb begin
      cand_nxt  = candidate;
      match_nxt = match_cnt;
      if (sample == candidate) begin
         match_nxt = (match_cnt >= DbMax) ? DbMax : match_cnt + 4'd1;
      end else begin
         cand_nxt  = sample;
         match_nxt = 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= StIdle;
         poll_cnt      <= '0;
         tmo_cnt       <= '0;
         match_cnt     <= '0;
         candidate     <= 1'b0;
         read_req      <= 1'b0;
         jump_level    <= 1'b0;
         jump_pulse    <= 1'b0;
         release_pulse <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         jump_pulse    <= 1'b0;
         release_pulse <= 1'b0;
         // A timeout later in this block overrides the clear.
         if (clear_err) timeout_err <= 1'b0;

         case (state)
            StIdle: begin
               if (enable) begin
                  if (poll_cnt == PollLast) begin
                     poll_cnt <= '0;
                     read_req <= 1'b1;
                     state    <= StReq;
                  end else begin
                     poll_cnt <= poll_cnt + 24'd1;
                  end
               end
            end
            StReq: begin
               if (!avm.avm_waitrequest) begin
                  read_req <= 1'b0;
                  tmo_cnt  <= '0;
                  state    <= StWaitData;
               end
            end
            StWaitData: begin
               if (avm.avm_readdatavalid) begin
                  state     <= StIdle;
                  candidate <= cand_nxt;
                  match_cnt <= match_nxt;
                  if (match_nxt == DbMax && cand_nxt != jump_level) begin
                     jump_level    <= cand_nxt;
                     jump_pulse    <= cand_nxt;
                     release_pulse <= !cand_nxt;
                  end
               end else if (tmo_cnt == TmoLast) begin
                  tmo_cnt     <= '0;
                  timeout_err <= 1'b1;
                  state       <= StIdle;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/jump_button_poller.md
JUMP_BUTTON_POLLER -- requirements
Module: jump_button_poller

Interface
REQ-001 Parameter POLL_DIV, default 50000, clock cycles between read issues; legal range 2..2^24-1.
REQ-002 Parameter DEBOUNCE_CNT, default 4, consecutive equal samples required to accept a new level; legal range 1..15.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles from read acceptance to readdatavalid; legal range 1..65535.
REQ-004 Parameter RD_ADDR, default 0, the 2-bit word address issued on every read.
REQ-005 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-006 Port: reset  in  1  synchronous, active-high reset.
REQ-007 Port: enable  in  1  polling enable.
REQ-008 Port: avm_address  out  2  Avalon-MM read address.
REQ-009 Port: avm_read  out  1  Avalon-MM read request.
REQ-010 Port: avm_waitrequest  in  1  slave stall; request is accepted in a cycle with avm_read=1 and avm_waitrequest=0.
REQ-011 Port: avm_readdata  in  32  read data; only bit 0 is used.
REQ-012 Port: avm_readdatavalid  in  1  qualifies avm_readdata.
REQ-013 Port: jump_level  out  1  debounced button level.
REQ-014 Port: jump_pulse  out  1  one-cycle strobe on debounced 0->1.
REQ-015 Port: release_pulse  out  1  one-cycle strobe on debounced 1->0.
REQ-016 Port: timeout_err  out  1  sticky read-timeout flag.
REQ-017 Port: clear_err  in  1  clears timeout_err.

Function
REQ-018 The FSM SHALL have states IDLE, REQ and WAIT_DATA; one outstanding read at most.
REQ-019 IDLE: poll counter increments each cycle while enable=1; holds while enable=0; at count POLL_DIV-1 it clears and the FSM enters REQ next cycle.
REQ-020 REQ: avm_read=1, avm_address=RD_ADDR, both stable until acceptance; on acceptance the next state is WAIT_DATA.
REQ-021 Deasserting enable in REQ or WAIT_DATA SHALL NOT abort the transaction; the read completes normally.
REQ-022 avm_address SHALL be RD_ADDR in every cycle, including outside REQ.
REQ-023 WAIT_DATA: timeout counter starts at 0 on entry and increments each cycle without readdatavalid; readdatavalid returns to IDLE with sample = avm_readdata[0].
REQ-024 readdatavalid outside WAIT_DATA SHALL be ignored.
REQ-025 Timeout counter reaching TIMEOUT without readdatavalid: sample discarded, timeout_err set, debounce state unchanged, return to IDLE.
REQ-026 Debounce: sample equal to candidate -> match count increments, saturating at DEBOUNCE_CNT; otherwise candidate = sample, count = 1.
REQ-027 When count reaches DEBOUNCE_CNT and candidate differs from jump_level, jump_level SHALL update on the next edge, and jump_pulse (new 1) or release_pulse (new 0) SHALL be high for exactly that one cycle.
REQ-028 Latency: jump_level/pulse change 1 cycle after the readdatavalid cycle carrying the qualifying sample.
REQ-029 A single sample SHALL NOT produce more than one pulse; pulses never overlap.
REQ-030 clear_err=1 clears timeout_err next edge; a timeout in the same cycle as clear_err SHALL leave timeout_err set (set wins).

Reset
REQ-031 reset=1 SHALL, on the next edge: FSM to IDLE, avm_read=0, poll/timeout/match counters=0, candidate=0, jump_level=0, jump_pulse=0, release_pulse=0, timeout_err=0.
REQ-032 Reset during REQ or WAIT_DATA SHALL abandon the transaction; a later stray readdatavalid is ignored per REQ-024.
REQ-033 Reset overrides enable, clear_err and all bus inputs.

Verification
REQ-034 POLL_DIV=4, DEBOUNCE_CNT=2, waitrequest=0, slave returns 1 one cycle after acceptance -> read every 6 cycles; jump_level=1 and single jump_pulse one cycle after second valid sample.
REQ-035 Samples 1,0,1,1 with DEBOUNCE_CNT=2 -> exactly one jump_pulse, after the 4th sample; no release_pulse.
REQ-036 waitrequest held high 3 cycles in REQ -> avm_read and avm_address=RD_ADDR stable all 4 cycles; exactly one acceptance.
REQ-037 TIMEOUT=5, no readdatavalid -> timeout_err=1 after 5 WAIT_DATA cycles, FSM back in IDLE, jump_level unchanged; clear_err -> 0 next cycle.
REQ-038 reset asserted in WAIT_DATA with jump_level=1 -> all outputs 0 next edge; readdatavalid next cycle produces no level change.
REQ-039 enable dropped mid-REQ -> read completes, then poll counter holds; no new read until enable returns.
